unidade_controle_jogo: RTL and testbench
========================================

# unidade_controle_jogo

Moore/Mealy game sequencer for the PoliLobinho werewolf datapath (`fluxo_dados`). It runs one complete match:
- seed selection and loading;
- role reveal for five players;
- night actions for each living player;
- night elimination;
- timed discussion;
- group vote and execution;
- win detection.

Every datapath control strobe comes from this block. The block consumes only datapath status flags and two pre-debounced, edge-detected button pulses.

## Interface
Parameters: none. Player count 5 and timeout (3 min) are fixed in the datapath.

Ports:
- clock  in  1  system clock (same domain as `fluxo_dados.clock`)
- reset  in  1  asynchronous, active-low; forces INICIAL
- iniciar  in  1  one-cycle pulse: start match
- confirmar  in  1  one-cycle pulse: player confirms current step
- CJ_fim  in  1  player counter at last player (4)
- jogador_vivo  in  1  current player alive
- jogou  in  1  last night action valid (registered)
- votou  in  1  last vote valid (registered, one cycle wide)
- timeout  in  1  discussion time expired
- sinal_lobo_ganhou  in  1  three deaths reached
- acertou  in  1  voted player is the wolf
- rst_global, zera_CS, zera_CJ, zera_CT, inc_seed, e_seed_reg, inc_jogador, mostra_classe, processar_acao, avaliar_eliminacao, discussao, voto, morra, reset_Pular  out  1 each  datapath strobes
- lobo_ganhou  out  1  high in LOBO_VENCE
- aldeia_ganhou  out  1  high in ALDEIA_VENCE
- db_estado  out  5  current state code

## Operation
State codes are given in parentheses. Unlisted outputs are 0.
- INICIAL (0):
  - Outputs: rst_global=1, zera_CJ=1, zera_CT=1, inc_seed=1 (seed free-runs while idle).
  - iniciar -> CARREGA_SEED.
- CARREGA_SEED (1): e_seed_reg=1 -> MOSTRA.
- MOSTRA (2):
  - Output: mostra_classe=1.
  - confirmar -> PROX_MOSTRA.
- PROX_MOSTRA (3):
  - CJ_fim: zera_CJ=1 -> NOITE.
  - Otherwise: inc_jogador=1 -> MOSTRA.
- NOITE (4):
  - !jogador_vivo -> PROX_NOITE.
  - jogador_vivo and confirmar -> ACAO.
- ACAO (5): processar_acao=1 -> CHECA_ACAO.
- CHECA_ACAO (6):
  - jogou -> PROX_NOITE.
  - Otherwise -> NOITE (same player retries).
- PROX_NOITE (7):
  - CJ_fim: zera_CJ=1 -> ELIMINA.
  - Otherwise: inc_jogador=1 -> NOITE.
- ELIMINA (8): avaliar_eliminacao=1 -> CHECA_NOITE.
- CHECA_NOITE (9):
  - Output: zera_CT=1.
  - sinal_lobo_ganhou -> LOBO_VENCE.
  - Otherwise -> DISCUSSAO.
- DISCUSSAO (10):
  - Output: discussao=1.
  - confirmar or timeout -> VOTACAO. Both in the same cycle: a single transition.
- VOTACAO (11): confirmar -> VOTA.
- VOTA (12): voto=1 -> CHECA_VOTO.
- CHECA_VOTO (13):
  - votou -> EXECUTA.
  - Otherwise -> VOTACAO (invalid target, e.g. a dead player).
- EXECUTA (14): morra=1 -> RESULTADO.
- RESULTADO (15):
  - acertou -> ALDEIA_VENCE.
  - Else sinal_lobo_ganhou -> LOBO_VENCE.
  - Else reset_Pular=1, zera_CJ=1, zera_CT=1 -> NOITE.
- LOBO_VENCE (16):
  - Output: lobo_ganhou=1.
  - confirmar -> INICIAL.
- ALDEIA_VENCE (17):
  - Output: aldeia_ganhou=1.
  - confirmar -> INICIAL.
- Codes 18–31 are illegal and go to INICIAL on the next edge.
- Outputs are combinational from the state register plus the listed input qualifiers (PROX_*, RESULTADO). They are glitch-tolerant because the datapath samples them only on `clock`.
- The wolf also acts in NOITE. The datapath validates the target; the controller only retries on !jogou.

## Timing
- Reset:
  - Reset low forces INICIAL asynchronously.
  - Output values while reset is low: rst_global=1, zera_CJ=1, zera_CT=1, inc_seed=1; all other outputs 0; db_estado=0.
  - Reset asserted mid-match abandons the match; the datapath is cleared by rst_global on the next edge.
- Single-cycle strobes: e_seed_reg, processar_acao, avaliar_eliminacao, voto, morra, reset_Pular and inc_jogador are each exactly one clock wide per visit.
- CHECA_ACAO samples jogou one edge after processar_acao. CHECA_VOTO samples votou one edge after voto.
- CHECA_NOITE and RESULTADO sample sinal_lobo_ganhou after the mortes update edge.
- iniciar and confirmar are ignored in every state that does not list them.
- iniciar and confirmar together in INICIAL: iniciar wins.
- Minimum night latency: NOITE -> ACAO -> CHECA_ACAO -> PROX_NOITE, which is 4 cycles per living player after confirmar.
- Dead player: NOITE -> PROX_NOITE in 1 cycle, no confirmar needed.
- Player counter wrap is handled by zera_CJ only; inc_jogador is never asserted while CJ_fim=1.

## Test plan
- **Reset:** reset=0 while in VOTA → db_estado=0 immediately; rst_global=1, voto=0.
- **Setup and reveal:** iniciar, then 5 confirmar pulses → e_seed_reg high for exactly 1 cycle; mostra_classe high in MOSTRA; inc_jogador pulses 4 times; zera_CJ on the 5th; db_estado=4.
- **Night with dead player:** jogador_vivo=0 for player 2 → NOITE->PROX_NOITE with no processar_acao. jogou=0 once on player 3 → returns to NOITE; the retry succeeds.
- **Night kill ends game:** night kill with sinal_lobo_ganhou=1 at CHECA_NOITE → LOBO_VENCE, lobo_ganhou=1; confirmar → INICIAL.
- **Discussion timeout:** hold in DISCUSSAO, raise timeout with no confirmar → VOTACAO next edge; discussao=0 thereafter.
- **Vote outcomes:**
  - votou=0 → back to VOTACAO, no morra.
  - Valid vote with acertou=1 → morra 1 cycle, then aldeia_ganhou=1.
  - Valid vote with acertou=0 and sinal_lobo_ganhou=0 → reset_Pular=1, next state NOITE.

Source files
------------

// File: rtl/unidade_controle_jogo.sv
// Match sequencer for the PoliLobinho datapath (fluxo_dados).
// Walks one complete match: seed load, role reveal, night actions, night
// elimination, timed discussion, vote/execution and win detection. Every
// datapath strobe comes from here; the only inputs are datapath status flags
// and two already debounced, edge-detected button pulses.
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,        // async, active-low
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic       CJ_fim,
  input  logic       jogador_vivo,
  input  logic       jogou,
  input  logic       votou,
  input  logic       timeout,
  input  logic       sinal_lobo_ganhou,
  input  logic       acertou,
  output logic       rst_global,
  output logic       zera_CS,
  output logic       zera_CJ,
  output logic       zera_CT,
  output logic       inc_seed,
  output logic       e_seed_reg,
  output logic       inc_jogador,
  output logic       mostra_classe,
  output logic       processar_acao,
  output logic       avaliar_eliminacao,
  output logic       discussao,
  output logic       voto,
  output logic       morra,
  output logic       reset_Pular,
  output logic       lobo_ganhou,
  output logic       aldeia_ganhou,
  output logic [4:0] db_estado
);

  typedef enum logic [4:0] {
    INICIAL      = 5'd0,
    CARREGA_SEED = 5'd1,
    MOSTRA       = 5'd2,
    PROX_MOSTRA  = 5'd3,
    NOITE        = 5'd4,
    ACAO         = 5'd5,
    CHECA_ACAO   = 5'd6,
    PROX_NOITE   = 5'd7,
    ELIMINA      = 5'd8,
    CHECA_NOITE  = 5'd9,
    DISCUSSAO    = 5'd10,
    VOTACAO      = 5'd11,
    VOTA         = 5'd12,
    CHECA_VOTO   = 5'd13,
    EXECUTA      = 5'd14,
    RESULTADO    = 5'd15,
    LOBO_VENCE   = 5'd16,
    ALDEIA_VENCE = 5'd17
  } estado_t;

  estado_t estado_q, estado_d;

  // State register; reset drops straight back to INICIAL, abandoning any match.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_q <= INICIAL;
    else        estado_q <= estado_d;
  end

  // Next-state and strobe decode. Strobes are Moore except where a flag
  // qualifies them (PROX_*, RESULTADO); the datapath only samples on clock,
  // so combinational glitches are harmless.
  always_comb begin
    estado_d           = estado_q;
    rst_global         = 1'b0;
    zera_CS            = 1'b0;
    zera_CJ            = 1'b0;
    zera_CT            = 1'b0;
    inc_seed           = 1'b0;
    e_seed_reg         = 1'b0;
    inc_jogador        = 1'b0;
    mostra_classe      = 1'b0;
    processar_acao     = 1'b0;
    avaliar_eliminacao = 1'b0;
    discussao          = 1'b0;
    voto               = 1'b0;
    morra              = 1'b0;
    reset_Pular        = 1'b0;
    lobo_ganhou        = 1'b0;
    aldeia_ganhou      = 1'b0;

    case (estado_q)
      INICIAL: begin
        // Seed counter free-runs while idle so the match seed depends on
        // when the player presses start.
        rst_global = 1'b1;
        zera_CJ    = 1'b1;
        zera_CT    = 1'b1;
        inc_seed   = 1'b1;
        if (iniciar) estado_d = CARREGA_SEED;
      end

      CARREGA_SEED: begin
        e_seed_reg = 1'b1;
        estado_d   = MOSTRA;
      end

      MOSTRA: begin
        mostra_classe = 1'b1;
        if (confirmar) estado_d = PROX_MOSTRA;
      end

      PROX_MOSTRA: begin
        // Counter wrap is done by zera_CJ alone; never increment at the last player.
        if (CJ_fim) begin
          zera_CJ  = 1'b1;
          estado_d = NOITE;
        end else begin
          inc_jogador = 1'b1;
          estado_d    = MOSTRA;
        end
      end

      NOITE: begin
        // Dead players are skipped without waiting for a button press.
        if (!jogador_vivo)  estado_d = PROX_NOITE;
        else if (confirmar) estado_d = ACAO;
      end

      ACAO: begin
        processar_acao = 1'b1;
        estado_d       = CHECA_ACAO;
      end

      CHECA_ACAO: begin
        // jogou is registered by the datapath on the processar_acao edge;
        // an invalid target sends the same player back to choose again.
        estado_d = jogou ? PROX_NOITE : NOITE;
      end

      PROX_NOITE: begin
        if (CJ_fim) begin
          zera_CJ  = 1'b1;
          estado_d = ELIMINA;
        end else begin
          inc_jogador = 1'b1;
          estado_d    = NOITE;
        end
      end

      ELIMINA: begin
        avaliar_eliminacao = 1'b1;
        estado_d           = CHECA_NOITE;
      end

      CHECA_NOITE: begin
        // Clear the discussion timer here so DISCUSSAO starts from zero.
        zera_CT  = 1'b1;
        estado_d = sinal_lobo_ganhou ? LOBO_VENCE : DISCUSSAO;
      end

      DISCUSSAO: begin
        discussao = 1'b1;
        if (confirmar || timeout) estado_d = VOTACAO;
      end

      VOTACAO: begin
        if (confirmar) estado_d = VOTA;
      end

      VOTA: begin
        voto     = 1'b1;
        estado_d = CHECA_VOTO;
      end

      CHECA_VOTO: begin
        // Vote on an invalid target (e.g. a dead player) is simply retaken.
        estado_d = votou ? EXECUTA : VOTACAO;
      end

      EXECUTA: begin
        morra    = 1'b1;
        estado_d = RESULTADO;
      end

      RESULTADO: begin
        // Village win takes priority over a simultaneous wolf death count.
        if (acertou) begin
          estado_d = ALDEIA_VENCE;
        end else if (sinal_lobo_ganhou) begin
          estado_d = LOBO_VENCE;
        end else begin
          reset_Pular = 1'b1;
          zera_CJ     = 1'b1;
          zera_CT     = 1'b1;
          estado_d    = NOITE;
        end
      end

      LOBO_VENCE: begin
        lobo_ganhou = 1'b1;
        if (confirmar) estado_d = INICIAL;
      end

      ALDEIA_VENCE: begin
        aldeia_ganhou = 1'b1;
        if (confirmar) estado_d = INICIAL;
      end

      // Codes 18..31: recover to idle on the next edge with all strobes low.
      default: estado_d = INICIAL;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo: three matches covering reveal,
// night skips/retries, timeout, vote retry, both win paths and async reset.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, confirmar, CJ_fim, jogador_vivo, jogou, votou;
  logic       timeout, sinal_lobo_ganhou, acertou;
  logic       rst_global, zera_CS, zera_CJ, zera_CT, inc_seed, e_seed_reg;
  logic       inc_jogador, mostra_classe, processar_acao, avaliar_eliminacao;
  logic       discussao, voto, morra, reset_Pular, lobo_ganhou, aldeia_ganhou;
  logic [4:0] db_estado;

  int checks = 0;
  int errors = 0;

  unidade_controle_jogo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .confirmar(confirmar),
    .CJ_fim(CJ_fim), .jogador_vivo(jogador_vivo), .jogou(jogou), .votou(votou),
    .timeout(timeout), .sinal_lobo_ganhou(sinal_lobo_ganhou), .acertou(acertou),
    .rst_global(rst_global), .zera_CS(zera_CS), .zera_CJ(zera_CJ),
    .zera_CT(zera_CT), .inc_seed(inc_seed), .e_seed_reg(e_seed_reg),
    .inc_jogador(inc_jogador), .mostra_classe(mostra_classe),
    .processar_acao(processar_acao), .avaliar_eliminacao(avaliar_eliminacao),
    .discussao(discussao), .voto(voto), .morra(morra),
    .reset_Pular(reset_Pular), .lobo_ganhou(lobo_ganhou),
    .aldeia_ganhou(aldeia_ganhou), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Inputs change 2 time units after the rising edge; outputs are checked 1
  // unit later, well away from the next edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // INICIAL -> reveal of 5 players -> NOITE.
  task automatic reveal();
    chk5("idle_state", db_estado, 5'd0);
    chk1("idle_inc_seed", inc_seed, 1'b1);
    iniciar = 1'b1; confirmar = 1'b1;   // iniciar wins in INICIAL
    tick();
    iniciar = 1'b0; confirmar = 1'b0;
    #1;
    chk5("carrega_state", db_estado, 5'd1);
    chk1("e_seed_on", e_seed_reg, 1'b1);
    tick(); #1;
    chk5("mostra_state", db_estado, 5'd2);
    chk1("e_seed_one_cycle", e_seed_reg, 1'b0);
    for (int i = 0; i < 5; i++) begin
      CJ_fim = (i == 4);
      #1;
      chk1("mostra_classe", mostra_classe, 1'b1);
      chk1("mostra_no_inc", inc_jogador, 1'b0);
      confirmar = 1'b1;
      tick();
      confirmar = 1'b0;
      #1;
      chk5("prox_mostra_state", db_estado, 5'd3);
      chk1("prox_mostra_inc", inc_jogador, (i < 4));
      chk1("prox_mostra_zera_cj", zera_CJ, (i == 4));
      tick(); #1;
      chk5("after_prox_mostra", db_estado, (i == 4) ? 5'd4 : 5'd2);
    end
    CJ_fim = 1'b0;
  endtask

  // Night for 5 players; dead/retry pick a player (5 = none). Ends after
  // CHECA_NOITE with sinal_lobo_ganhou = sinal.
  task automatic night(input int dead, input int retry, input logic sinal);
    for (int p = 0; p < 5; p++) begin
      CJ_fim = (p == 4);
      jogador_vivo = (p != dead);
      #1;
      chk5("noite_state", db_estado, 5'd4);
      if (p == dead) begin
        tick(); #1;
        chk5("dead_skip", db_estado, 5'd7);
        chk1("dead_no_acao", processar_acao, 1'b0);
      end else begin
        if (p == retry) begin
          confirmar = 1'b1; tick(); confirmar = 1'b0; #1;
          chk1("retry_acao", processar_acao, 1'b1);
          tick(); jogou = 1'b0; #1;
          chk5("retry_checa", db_estado, 5'd6);
          tick(); #1;
          chk5("retry_back_noite", db_estado, 5'd4);
        end
        confirmar = 1'b1; tick(); confirmar = 1'b0; #1;
        chk5("acao_state", db_estado, 5'd5);
        chk1("acao_strobe", processar_acao, 1'b1);
        tick(); jogou = 1'b1; #1;
        chk5("checa_acao_state", db_estado, 5'd6);
        chk1("acao_one_cycle", processar_acao, 1'b0);
        tick(); jogou = 1'b0; #1;
        chk5("prox_noite_state", db_estado, 5'd7);
      end
      chk1("prox_noite_inc", inc_jogador, (p < 4));
      chk1("prox_noite_zera_cj", zera_CJ, (p == 4));
      tick(); #1;
      chk5("after_prox_noite", db_estado, (p == 4) ? 5'd8 : 5'd4);
    end
    CJ_fim = 1'b0; jogador_vivo = 1'b1;
    chk1("elimina_strobe", avaliar_eliminacao, 1'b1);
    tick(); sinal_lobo_ganhou = sinal; #1;
    chk5("checa_noite_state", db_estado, 5'd9);
    chk1("checa_noite_zera_ct", zera_CT, 1'b1);
    chk1("elimina_one_cycle", avaliar_eliminacao, 1'b0);
    tick(); #1;
    chk5("after_checa_noite", db_estado, sinal ? 5'd16 : 5'd10);
    sinal_lobo_ganhou = 1'b0;
  endtask

  // From VOTACAO: one valid vote, then RESULTADO with given flags.
  task automatic valid_vote(input logic ac, input logic sinal, input logic [4:0] dest);
    confirmar = 1'b1; tick(); confirmar = 1'b0; #1;
    chk1("vota_strobe", voto, 1'b1);
    tick(); votou = 1'b1; #1;
    chk5("checa_voto_state", db_estado, 5'd13);
    tick(); votou = 1'b0; #1;
    chk5("executa_state", db_estado, 5'd14);
    chk1("morra_on", morra, 1'b1);
    tick(); acertou = ac; sinal_lobo_ganhou = sinal; #1;
    chk5("resultado_state", db_estado, 5'd15);
    chk1("morra_one_cycle", morra, 1'b0);
    chk1("resultado_reset_pular", reset_Pular, (!ac && !sinal));
    tick(); acertou = 1'b0; sinal_lobo_ganhou = 1'b0; #1;
    chk5("after_resultado", db_estado, dest);
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; confirmar = 1'b0; CJ_fim = 1'b0;
    jogador_vivo = 1'b1; jogou = 1'b0; votou = 1'b0; timeout = 1'b0;
    sinal_lobo_ganhou = 1'b0; acertou = 1'b0;
    #1;
    chk5("reset_state", db_estado, 5'd0);
    chk1("reset_rst_global", rst_global, 1'b1);
    chk1("reset_inc_seed", inc_seed, 1'b1);
    chk1("reset_zera_cs", zera_CS, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // Match 1: dead player 2, retry on player 3, timeout, vote retry, no win.
    reveal();
    night(2, 3, 1'b0);
    #1;
    chk1("discussao_on", discussao, 1'b1);
    tick(); #1;
    chk5("discussao_hold", db_estado, 5'd10);
    timeout = 1'b1; tick(); timeout = 1'b0; #1;
    chk5("timeout_to_votacao", db_estado, 5'd11);
    chk1("discussao_off", discussao, 1'b0);
    confirmar = 1'b1; tick(); confirmar = 1'b0; #1;
    chk5("vota_state", db_estado, 5'd12);
    tick(); votou = 1'b0; #1;
    tick(); #1;
    chk5("invalid_vote_back", db_estado, 5'd11);
    chk1("invalid_vote_no_morra", morra, 1'b0);
    valid_vote(1'b0, 1'b0, 5'd4);

    // Second night kill ends the game for the wolf.
    night(2, 5, 1'b1);
    chk1("lobo_ganhou", lobo_ganhou, 1'b1);
    iniciar = 1'b1; tick(); iniciar = 1'b0; #1;
    chk5("lobo_ignores_iniciar", db_estado, 5'd16);
    confirmar = 1'b1; tick(); confirmar = 1'b0; #1;
    chk5("lobo_to_inicial", db_estado, 5'd0);
    chk1("lobo_off", lobo_ganhou, 1'b0);

    // Match 2: confirmar+timeout together, then reset while in VOTA.
    reveal();
    night(5, 5, 1'b0);
    confirmar = 1'b1; timeout = 1'b1; tick(); confirmar = 1'b0; timeout = 1'b0; #1;
    chk5("both_to_votacao", db_estado, 5'd11);
    confirmar = 1'b1; tick(); confirmar = 1'b0; #1;
    chk5("vota_before_reset", db_estado, 5'd12);
    reset = 1'b0; #1;
    chk5("async_reset_state", db_estado, 5'd0);
    chk1("async_reset_rst_global", rst_global, 1'b1);
    chk1("async_reset_voto", voto, 1'b0);
    chk1("async_reset_zera_cj", zera_CJ, 1'b1);
    tick(); reset = 1'b1; #1;
    chk5("after_reset_release", db_estado, 5'd0);

    // Match 3: confirmar ends discussion, correct vote -> village wins.
    reveal();
    night(0, 5, 1'b0);
    confirmar = 1'b1; tick(); confirmar = 1'b0; #1;
    chk5("confirm_to_votacao", db_estado, 5'd11);
    valid_vote(1'b1, 1'b1, 5'd17);
    chk1("aldeia_ganhou", aldeia_ganhou, 1'b1);
    chk1("aldeia_no_lobo", lobo_ganhou, 1'b0);
    confirmar = 1'b1; tick(); confirmar = 1'b0; #1;
    chk5("aldeia_to_inicial", db_estado, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
